rv_wb_checker: RTL and testbench
================================

Name: rv_wb_checker

Overview:
- Synthesizable, self-checking writeback monitor for rv32i instruction-verification benches.
- Sits beside the core and snoops the register-file write port.
- Compares an ordered list of up to MAX_CHECKS expected (rd, value) pairs against actual writebacks.
- Reports pass, fail or timeout, replacing manual $monitor inspection of R1..R3 per instruction test.

Parameters:
XLEN, 32, data width of writeback values
MAX_CHECKS, 8, depth of expectation table (power of 2, >=2)
TIMEOUT_W, 16, width of cycle timeout counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  write one expectation entry (accepted in IDLE, PASS, FAIL and TIMEOUT only)
cfg_idx  input  clog2(MAX_CHECKS)  entry index
cfg_rd  input  5  expected destination register
cfg_value  input  XLEN  expected value
num_checks  input  clog2(MAX_CHECKS)+1  number of valid entries (0..MAX_CHECKS), sampled at start
timeout_cycles  input  TIMEOUT_W  cycle budget, sampled at start; 0 = no timeout
start  input  1  one-cycle pulse to begin checking
wb_valid  input  1  core register-file write enable this cycle
wb_rd  input  5  core write address
wb_data  input  XLEN  core write data
busy  output  1  high in RUN
done  output  1  high in PASS, FAIL or TIMEOUT
pass  output  1  high only in PASS
timed_out  output  1  high only in TIMEOUT
check_ptr  output  clog2(MAX_CHECKS)+1  number of checks matched so far
fail_data  output  XLEN  wb_data captured on mismatch

Behaviour:
- Async reset:
  - state = IDLE; all outputs 0; check_ptr = 0; fail_data = 0.
  - Expectation table contents after reset are don't-care.
- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT.
- cfg_we:
  - Writes table[cfg_idx] on the clock edge in every state except RUN.
  - Ignored in RUN. Table contents are not modified.
- start:
  - Accepted in any state except RUN; ignored in RUN.
  - Latches num_checks and timeout_cycles, clears check_ptr, fail_data and the cycle counter, and enters RUN next cycle.
  - If latched num_checks == 0: enters PASS directly (done asserts 1 cycle after start).
- RUN, per cycle:
  - wb_valid=0: no compare.
  - wb_valid=1, wb_rd=0: ignored (x0 writes never checked).
  - wb_valid=1, wb_rd != table[check_ptr].rd: ignored. Writes to unchecked registers are permitted.
  - wb_valid=1, wb_rd == table[check_ptr].rd, wb_data == value: check_ptr increments. If the new check_ptr == latched num_checks, go to PASS.
  - wb_valid=1, wb_rd matches, wb_data != value: go to FAIL. fail_data = wb_data. check_ptr holds, which gives the failing index.
- Compare is a registered decision: the outcome is visible on outputs 1 cycle after the wb cycle.
- Timeout:
  - Counter increments every RUN cycle.
  - When the counter == latched timeout_cycles (nonzero), go to TIMEOUT.
  - Simultaneous final match and timeout in the same cycle: PASS wins.
  - Simultaneous mismatch and timeout: FAIL wins.
- PASS, FAIL and TIMEOUT are sticky until the next start or reset. Outputs hold.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs cleared. No partial result is retained.
- Num_checks > MAX_CHECKS at start: clamped to MAX_CHECKS.
- Values compare as raw XLEN bits. No sign interpretation.

Test Plan:
- SLTI first case:
  - Table: {rd=1, 0xFFFFFFFF}, {rd=2, 0x00000000}; num_checks=2; timeout=20; pulse start.
  - Drive wb (1, 0xFFFFFFFF), then wb (2, 0).
  - Expect pass=1, done=1 one cycle after the 2nd wb, check_ptr=2.
- SLTI wrong result:
  - Same table; drive wb (1, 0xFFFFFFFF), then wb (2, 1).
  - Expect FAIL: done=1, pass=0, check_ptr=1, fail_data=1.
- Interleaved and ignored writes:
  - Table {rd=3, 0x5}; drive wb (0, 0xDEAD), wb (7, 0x1), wb (3, 0x5).
  - Expect PASS. x0 and x7 writes do not affect the result.
- Timeout:
  - Table {rd=2, 0}, timeout=10, no wb_valid.
  - Expect timed_out=1, done=1 after 10 RUN cycles, pass=0.
  - Repeat with timeout=0 and 50 idle cycles: expect busy=1 throughout.
- Boundary:
  - num_checks=0 + start: expect PASS on the next cycle.
  - Final match on the same cycle the counter hits the timeout: expect PASS.
  - cfg_we during RUN: the table is unchanged, confirmed by a rerun.
- Reset mid-RUN:
  - Assert reset after 1 of 2 matches.
  - Expect busy=0, done=0 and check_ptr=0 immediately (asynchronous), with no clock edge required.

Source files
------------

// File: rtl/rv_wb_checker_if.sv
// Bundle of configuration, writeback-snoop and result signals for the
// writeback checker. The master side is the bench/core harness, the slave
// side is the checker itself.
interface rv_wb_checker_if #(
  parameter int XLEN       = 32,
  parameter int MAX_CHECKS = 8,
  parameter int TIMEOUT_W  = 16
);
  localparam int CW = $clog2(MAX_CHECKS);

  // Handshake: cfg_we and start are single-cycle strobes without
  // back-pressure (always accepted outside RUN, dropped in RUN); wb_valid
  // qualifies wb_rd/wb_data in the cycle it is high and has no ready.
  logic                 cfg_we;
  logic [CW-1:0]        cfg_idx;
  logic [4:0]           cfg_rd;
  logic [XLEN-1:0]      cfg_value;
  logic [CW:0]          num_checks;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 start;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timed_out;
  logic [CW:0]          check_ptr;
  logic [XLEN-1:0]      fail_data;

  modport master (
    output cfg_we, cfg_idx, cfg_rd, cfg_value, num_checks, timeout_cycles,
    output start, wb_valid, wb_rd, wb_data,
    input  busy, done, pass, timed_out, check_ptr, fail_data
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_rd, cfg_value, num_checks, timeout_cycles,
    input  start, wb_valid, wb_rd, wb_data,
    output busy, done, pass, timed_out, check_ptr, fail_data
  );
endinterface

// File: rtl/rv_wb_checker.sv
// Writeback checker: snoops the register-file write port and matches an
// ordered table of expected (rd, value) pairs, reporting pass/fail/timeout.
module rv_wb_checker #(
  parameter int XLEN       = 32,
  parameter int MAX_CHECKS = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  rv_wb_checker_if.slave    bus,
  output logic [2:0]        dbg_state
);
  localparam int CW = $clog2(MAX_CHECKS);
  localparam logic [CW:0] MAX_N = (CW+1)'(MAX_CHECKS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW:0]          ptr_q, ptr_d;
  logic [CW:0]          num_q, num_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      fail_q, fail_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 tout_q, tout_d;

  // Expectation table; contents are meaningless until written, so no reset.
  logic [4:0]      tbl_rd  [MAX_CHECKS];
  logic [XLEN-1:0] tbl_val [MAX_CHECKS];

  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_val;
  logic            rd_hit;
  logic [CW:0]     ptr_inc;
  logic [TIMEOUT_W-1:0] cnt_inc;

  assign exp_rd  = tbl_rd[ptr_q[CW-1:0]];
  assign exp_val = tbl_val[ptr_q[CW-1:0]];
  assign rd_hit  = bus.wb_valid && (bus.wb_rd != 5'd0) && (bus.wb_rd == exp_rd);
  assign ptr_inc = ptr_q + (CW+1)'(1);
  assign cnt_inc = cnt_q + TIMEOUT_W'(1);

  // Table writes are locked out while a check sequence is running.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q != ST_RUN)) begin
      tbl_rd[bus.cfg_idx]  <= bus.cfg_rd;
      tbl_val[bus.cfg_idx] <= bus.cfg_value;
    end
  end

  // Next-state decision: start handling, ordered compare, then timeout
  // (a final match or a mismatch takes priority over an expiring budget).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_inc;
      if (rd_hit && (bus.wb_data == exp_val)) begin
        ptr_d = ptr_inc;
        if (ptr_inc == num_q) state_d = ST_PASS;
      end else if (rd_hit) begin
        state_d = ST_FAIL;
        fail_d  = bus.wb_data;
      end
      if ((state_d == ST_RUN) && (tmo_q != '0) && (cnt_inc == tmo_q)) begin
        state_d = ST_TIMEOUT;
      end
    end else if (bus.start) begin
      num_d   = (bus.num_checks > MAX_N) ? MAX_N : bus.num_checks;
      tmo_d   = bus.timeout_cycles;
      ptr_d   = '0;
      cnt_d   = '0;
      fail_d  = '0;
      state_d = (num_d == '0) ? ST_PASS : ST_RUN;
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d = (state_d == ST_PASS);
    tout_d = (state_d == ST_TIMEOUT);
  end

  // FSM and registered outputs; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      num_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timed_out = tout_q;
  assign bus.check_ptr = ptr_q;
  assign bus.fail_data = fail_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_rv_wb_checker.sv
// Directed bench for rv_wb_checker: hand-computed expectations checked with
// immediate assertions after each step.
module tb_rv_wb_checker;
  localparam int XLEN = 32;
  localparam int MAXC = 8;
  localparam int TW   = 16;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         total;
  int         bad;

  rv_wb_checker_if #(.XLEN(XLEN), .MAX_CHECKS(MAXC), .TIMEOUT_W(TW)) bus ();

  rv_wb_checker #(.XLEN(XLEN), .MAX_CHECKS(MAXC), .TIMEOUT_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: every step ends 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int idx, input logic [4:0] rd, input logic [31:0] val);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 3'(idx);
    bus.cfg_rd    = rd;
    bus.cfg_value = val;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic do_start(input int n, input int tmo);
    bus.num_checks     = 4'(n);
    bus.timeout_cycles = 16'(tmo);
    bus.start          = 1'b1;
    step();
    bus.start          = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_rd = '0; bus.cfg_value = '0;
    bus.num_checks = '0; bus.timeout_cycles = '0; bus.start = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

    // Reset state
    idle(2);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pass", 32'(bus.pass), 32'd0);
    check("rst_tout", 32'(bus.timed_out), 32'd0);
    check("rst_ptr", 32'(bus.check_ptr), 32'd0);
    check("rst_fail", bus.fail_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    idle(1);

    // SLTI first case
    cfg_write(0, 5'd1, 32'hFFFF_FFFF);
    cfg_write(1, 5'd2, 32'h0000_0000);
    do_start(2, 20);
    check("slti_run_busy", 32'(bus.busy), 32'd1);
    check("slti_run_done", 32'(bus.done), 32'd0);
    wb(5'd1, 32'hFFFF_FFFF);
    check("slti_ptr1", 32'(bus.check_ptr), 32'd1);
    check("slti_busy1", 32'(bus.busy), 32'd1);
    wb(5'd2, 32'h0);
    check("slti_pass", 32'(bus.pass), 32'd1);
    check("slti_done", 32'(bus.done), 32'd1);
    check("slti_ptr2", 32'(bus.check_ptr), 32'd2);
    check("slti_busy0", 32'(bus.busy), 32'd0);
    check("slti_state", 32'(dbg_state), 32'd2);
    idle(3);
    check("slti_sticky", 32'(bus.pass), 32'd1);

    // SLTI wrong result
    do_start(2, 20);
    check("bad_cleared", 32'(bus.done), 32'd0);
    wb(5'd1, 32'hFFFF_FFFF);
    wb(5'd2, 32'h1);
    check("bad_done", 32'(bus.done), 32'd1);
    check("bad_pass", 32'(bus.pass), 32'd0);
    check("bad_tout", 32'(bus.timed_out), 32'd0);
    check("bad_ptr", 32'(bus.check_ptr), 32'd1);
    check("bad_data", bus.fail_data, 32'h1);
    check("bad_state", 32'(dbg_state), 32'd3);

    // Interleaved and ignored writes
    cfg_write(0, 5'd3, 32'h5);
    do_start(1, 20);
    check("ilv_fail_clr", bus.fail_data, 32'h0);
    wb(5'd0, 32'hDEAD);
    check("ilv_x0_ptr", 32'(bus.check_ptr), 32'd0);
    check("ilv_x0_busy", 32'(bus.busy), 32'd1);
    wb(5'd7, 32'h1);
    check("ilv_x7_busy", 32'(bus.busy), 32'd1);
    wb(5'd3, 32'h5);
    check("ilv_pass", 32'(bus.pass), 32'd1);
    check("ilv_ptr", 32'(bus.check_ptr), 32'd1);

    // Timeout after 10 RUN cycles
    cfg_write(0, 5'd2, 32'h0);
    do_start(1, 10);
    idle(9);
    check("tmo_busy9", 32'(bus.busy), 32'd1);
    check("tmo_tout9", 32'(bus.timed_out), 32'd0);
    idle(1);
    check("tmo_tout", 32'(bus.timed_out), 32'd1);
    check("tmo_done", 32'(bus.done), 32'd1);
    check("tmo_pass", 32'(bus.pass), 32'd0);
    check("tmo_state", 32'(dbg_state), 32'd4);

    // No timeout when budget is 0
    do_start(1, 0);
    for (int i = 0; i < 50; i++) begin
      idle(1);
      check("notmo_busy", 32'(bus.busy), 32'd1);
    end
    wb(5'd2, 32'h0);
    check("notmo_pass", 32'(bus.pass), 32'd1);

    // num_checks = 0 passes on the next cycle
    do_start(0, 5);
    check("zero_pass", 32'(bus.pass), 32'd1);
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_ptr", 32'(bus.check_ptr), 32'd0);

    // num_checks above depth clamps to 8 entries
    for (int i = 0; i < 8; i++) cfg_write(i, 5'(i + 1), 32'(i * 3 + 7));
    do_start(15, 0);
    for (int i = 0; i < 7; i++) wb(5'(i + 1), 32'(i * 3 + 7));
    check("clamp_busy7", 32'(bus.busy), 32'd1);
    check("clamp_ptr7", 32'(bus.check_ptr), 32'd7);
    wb(5'd8, 32'd28);
    check("clamp_pass", 32'(bus.pass), 32'd1);
    check("clamp_ptr8", 32'(bus.check_ptr), 32'd8);

    // Final match coincides with timeout: pass wins
    cfg_write(0, 5'd1, 32'h11);
    do_start(1, 3);
    idle(2);
    wb(5'd1, 32'h11);
    check("race_pass", 32'(bus.pass), 32'd1);
    check("race_tout", 32'(bus.timed_out), 32'd0);

    // Mismatch coincides with timeout: fail wins
    do_start(1, 3);
    idle(2);
    wb(5'd1, 32'h12);
    check("racef_done", 32'(bus.done), 32'd1);
    check("racef_tout", 32'(bus.timed_out), 32'd0);
    check("racef_data", bus.fail_data, 32'h12);

    // cfg_we during RUN is ignored
    do_start(1, 0);
    cfg_write(0, 5'd5, 32'h99);
    check("cfgrun_busy", 32'(bus.busy), 32'd1);
    wb(5'd1, 32'h11);
    check("cfgrun_pass", 32'(bus.pass), 32'd1);
    do_start(1, 0);
    wb(5'd5, 32'h99);
    check("rerun_busy", 32'(bus.busy), 32'd1);
    wb(5'd1, 32'h11);
    check("rerun_pass", 32'(bus.pass), 32'd1);

    // Reset in the middle of RUN clears immediately
    cfg_write(0, 5'd1, 32'hFFFF_FFFF);
    cfg_write(1, 5'd2, 32'h0);
    do_start(2, 20);
    wb(5'd1, 32'hFFFF_FFFF);
    check("mid_ptr1", 32'(bus.check_ptr), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_ptr", 32'(bus.check_ptr), 32'd0);
    check("mid_state", 32'(dbg_state), 32'd0);
    idle(1);
    reset = 1'b0;
    idle(2);
    check("post_idle", 32'(dbg_state), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
